// File: rtl/calc_controller.sv
// calc_controller: sequences operand/operator/execute strobes from a keypad
// front end into A/B register loads and an ALU start/done handshake.
// Optional build macro: CALC_CHAIN_EN -- an operator pressed while a result is
// showing reloads A from alu_result so calculations can be chained.
module calc_controller #(
  parameter int ALU_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       num_valid,
  input  logic [3:0] num_data,
  input  logic       op_valid,
  input  logic [1:0] op_code,
  input  logic       eq_valid,
  input  logic       clr,
  input  logic       alu_done,
  input  logic [3:0] alu_result,
  output logic       write_addr,
  output logic       load,
  output logic [3:0] operand,
  output logic [1:0] alu_op,
  output logic       alu_start,
  output logic       result_ready,
  output logic       error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HAVE_A  = 3'd1,
    S_HAVE_OP = 3'd2,
    S_HAVE_B  = 3'd3,
    S_EXEC    = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6,
    S_BAD     = 3'd7
  } state_t;

  localparam logic [3:0] TO_W = 4'(ALU_TIMEOUT);

  state_t     r_state, w_state_nxt;
  logic       r_wa, w_wa_nxt;
  logic       r_load, w_load_nxt;
  logic [3:0] r_operand, w_operand_nxt;
  logic [1:0] r_alu_op, w_alu_op_nxt;
  logic       r_start, w_start_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  // Only the highest-priority strobe of a cycle is acted on; the rest drop.
  logic w_eq, w_op, w_num, w_done_ok;
  assign w_eq      = eq_valid & ~clr;
  assign w_op      = op_valid & ~clr & ~eq_valid;
  assign w_num     = num_valid & ~clr & ~eq_valid & ~op_valid;
  // The start cycle itself never counts as a completion.
  assign w_done_ok = alu_done & ~r_start;

`ifndef CALC_CHAIN_EN
  logic w_unused_result;
  assign w_unused_result = ^alu_result;
`endif

  // State and registered outputs; async reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wa      <= 1'b0;
      r_load    <= 1'b0;
      r_operand <= '0;
      r_alu_op  <= '0;
      r_start   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wa      <= w_wa_nxt;
      r_load    <= w_load_nxt;
      r_operand <= w_operand_nxt;
      r_alu_op  <= w_alu_op_nxt;
      r_start   <= w_start_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_wa_nxt      = r_wa;
    w_load_nxt    = 1'b0;
    w_operand_nxt = r_operand;
    w_alu_op_nxt  = r_alu_op;
    w_start_nxt   = 1'b0;
    w_cnt_nxt     = r_cnt;
    if (clr) begin
      w_state_nxt  = S_IDLE;
      w_alu_op_nxt = '0;
      w_cnt_nxt    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_num) begin
            w_load_nxt = 1'b1; w_wa_nxt = 1'b0; w_operand_nxt = num_data;
            w_state_nxt = S_HAVE_A;
          end
        end
        S_HAVE_A: begin
          if (w_op) begin
            w_alu_op_nxt = op_code;
            w_state_nxt  = S_HAVE_OP;
          end else if (w_num) begin
            w_load_nxt = 1'b1; w_wa_nxt = 1'b0; w_operand_nxt = num_data;
          end
        end
        S_HAVE_OP: begin
          if (w_op) begin
            w_alu_op_nxt = op_code;
          end else if (w_num) begin
            w_load_nxt = 1'b1; w_wa_nxt = 1'b1; w_operand_nxt = num_data;
            w_state_nxt = S_HAVE_B;
          end
        end
        S_HAVE_B: begin
          if (w_eq) begin
            w_start_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_EXEC;
          end else if (w_num) begin
            w_load_nxt = 1'b1; w_wa_nxt = 1'b1; w_operand_nxt = num_data;
          end
        end
        S_EXEC: begin
          if (w_done_ok)                 w_state_nxt = S_DONE;
          else if ((r_cnt + 4'd1) == TO_W) w_state_nxt = S_ERR;
          else                           w_cnt_nxt   = r_cnt + 4'd1;
        end
        S_DONE: begin
`ifdef CALC_CHAIN_EN
          if (w_op) begin
            w_alu_op_nxt = op_code;
            w_load_nxt = 1'b1; w_wa_nxt = 1'b0; w_operand_nxt = alu_result;
            w_state_nxt = S_HAVE_OP;
          end else
`endif
          if (w_num) begin
            w_load_nxt = 1'b1; w_wa_nxt = 1'b0; w_operand_nxt = num_data;
            w_state_nxt = S_HAVE_A;
          end
        end
        S_ERR:   w_state_nxt = S_ERR;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign write_addr   = r_wa;
  assign load         = r_load;
  assign operand      = r_operand;
  assign alu_op       = r_alu_op;
  assign alu_start    = r_start;
  assign result_ready = (r_state == S_DONE);
  assign error        = (r_state == S_ERR);
  assign state        = r_state;

endmodule

// File: tb/tb_calc_controller.sv
// Scoreboarded bench for calc_controller: the driver applies strobes at the
// falling edge, a reference model predicts the post-edge outputs into a
// queue, and a monitor pops and compares just after each rising edge.
module tb_calc_controller;
  localparam int TO = 4;
`ifdef CALC_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic num_valid = 0, op_valid = 0, eq_valid = 0, clr = 0, alu_done = 0;
  logic [3:0] num_data = '0, alu_result = '0;
  logic [1:0] op_code = '0;
  logic write_addr, load, alu_start, result_ready, error;
  logic [3:0] operand;
  logic [1:0] alu_op;
  logic [2:0] state;

  calc_controller #(.ALU_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .num_valid(num_valid), .num_data(num_data),
    .op_valid(op_valid), .op_code(op_code), .eq_valid(eq_valid), .clr(clr),
    .alu_done(alu_done), .alu_result(alu_result), .write_addr(write_addr),
    .load(load), .operand(operand), .alu_op(alu_op), .alu_start(alu_start),
    .result_ready(result_ready), .error(error), .state(state));

  always #5 clk = ~clk;

  typedef struct {
    int       st;
    bit       ld;
    bit       wa;
    int       opnd;
    int       aop;
    bit       start;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0, n_total = 0;

  // Reference model: calculator state in plain integers.
  int m_st = 0, m_aop = 0, m_age = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus plus its predicted outcome.
  task automatic step(input bit c, input bit e, input bit o, input bit n,
                      input int d, input int oc, input bit dn, input int res);
    exp_t x;
    @(negedge clk);
    clr = c; eq_valid = e; op_valid = o; num_valid = n;
    num_data = 4'(d); op_code = 2'(oc); alu_done = dn; alu_result = 4'(res);
    x.ld = 0; x.wa = 0; x.opnd = 0; x.start = 0;
    if (c) begin
      m_st = 0; m_aop = 0;
    end else if (m_st == 4) begin
      // m_age = number of executing cycles already spent
      if (m_age > 0 && dn)      m_st = 5;
      else if (m_age + 1 == TO) m_st = 6;
      else                      m_age++;
    end else if (e) begin
      if (m_st == 3) begin m_st = 4; m_age = 0; x.start = 1; end
    end else if (o) begin
      if (m_st == 1 || m_st == 2) begin m_aop = oc; m_st = 2; end
      else if (CHAIN && m_st == 5) begin
        m_aop = oc; x.ld = 1; x.wa = 0; x.opnd = res; m_st = 2;
      end
    end else if (n) begin
      if (m_st == 0 || m_st == 1 || m_st == 5) begin
        x.ld = 1; x.wa = 0; x.opnd = d; m_st = 1;
      end else if (m_st == 2 || m_st == 3) begin
        x.ld = 1; x.wa = 1; x.opnd = d; m_st = 3;
      end
    end
    x.st = m_st; x.aop = m_aop;
    exp_q.push_back(x);
  endtask

  task automatic idle(input bit dn);          step(0,0,0,0,0,0,dn,0); endtask
  task automatic num(input int d);            step(0,0,0,1,d,0,0,0);  endtask
  task automatic op(input int oc);            step(0,0,1,0,0,oc,0,0); endtask
  task automatic eq();                        step(0,1,0,0,0,0,0,0);  endtask
  task automatic clear();                     step(1,0,0,0,0,0,0,0);  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_load"}, load, 0);
    chk({tag, "_waddr"}, write_addr, 0);
    chk({tag, "_operand"}, operand, 0);
    chk({tag, "_aluop"}, alu_op, 0);
    chk({tag, "_start"}, alu_start, 0);
    chk({tag, "_ready"}, result_ready, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  // Asynchronous reset landing mid-cycle; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    clr = 0; eq_valid = 0; op_valid = 0; num_valid = 0; alu_done = 0;
    #1 rst_n = 0;
    #1 chk_all_zero(tag);
    #1 rst_n = 1;
    m_st = 0; m_aop = 0; m_age = 0;
  endtask

  // Monitor: compare each predicted outcome just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", state, e.st);
        chk("load", load, int'(e.ld));
        chk("alu_start", alu_start, int'(e.start));
        chk("alu_op", alu_op, e.aop);
        chk("result_ready", result_ready, int'(e.st == 5));
        chk("error", error, int'(e.st == 6));
        if (e.ld) begin
          chk("write_addr", write_addr, int'(e.wa));
          chk("operand", operand, e.opnd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // power-on reset
    #12 chk_all_zero("por");
    #1 rst_n = 1;

    // basic A op B = sequence, done two cycles after eq
    num(3); op(1); num(5); eq(); idle(0); idle(1);
    settle();
    chk("seq_ready", result_ready, 1);
    chk("seq_state", state, 5);
    chk("seq_aluop", alu_op, 1);

    // repeated digit overwrites A
    clear(); num(7); num(9);
    settle();
    chk("ovr_state", state, 1);
    chk("ovr_operand", operand, 9);

    // timeout after TO executing cycles, then clear
    op(2); num(4); eq(); idle(0); idle(0); idle(0);
    settle();
    chk("to_still_exec", state, 4);
    idle(0);
    settle();
    chk("to_state", state, 6);
    chk("to_error", error, 1);
    num(1); eq();
    settle();
    chk("err_sticky", state, 6);
    clear();
    settle();
    chk("to_clr", state, 0);

    // eq beats num in HAVE_B
    num(2); op(3); num(6); step(0,1,0,1,11,0,0,0);
    settle();
    chk("prio_state", state, 4);
    chk("prio_noload", load, 0);

    // reset while executing
    async_reset("rst_exec");

`ifdef CALC_CHAIN_EN
    num(3); op(0); num(4); eq(); idle(0); idle(1);
    step(0,0,1,0,0,2,0,8);
    settle();
    chk("chain_load", load, 1);
    chk("chain_waddr", write_addr, 0);
    chk("chain_operand", operand, 8);
    chk("chain_state", state, 2);
    chk("chain_aluop", alu_op, 2);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 40,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 35, int'($urandom_range(0, 15)));
    end
    settle();
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
